// File: rtl/array_ram_pkg.sv
// ----------------------------------------------------------------------------
// array_ram_pkg
// Shared definitions for the Array channel word memory: default widths,
// the two-state handshake FSM encoding and a helper that sizes the internal
// word index for a given depth.
// ----------------------------------------------------------------------------
package array_ram_pkg;

    localparam int ARRAY_ADDR_N = 8;   // default address width
    localparam int ARRAY_INT_N  = 8;   // default data width

    // Handshake FSM: IDLE accepts a request, ACK raises ready for one cycle.
    typedef enum logic {
        ARRAY_IDLE = 1'b0,
        ARRAY_ACK  = 1'b1
    } array_state_e;

    // Bits needed to index 'depth' words; never less than one bit.
    function automatic int array_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/array_ram_core.sv
// ----------------------------------------------------------------------------
// array_ram_core
// Plain inferred word RAM with no handshake or control: synchronous write,
// combinational read of the addressed word.
//
// Ports:
//   clk   in   1       write clock
//   we    in   1       write enable for this edge
//   addr  in   IDX_W   word index (always < DEPTH)
//   di    in   DATA_W  write data
//   dout  out  DATA_W  contents of mem[addr]
// ----------------------------------------------------------------------------
module array_ram_core #(
    parameter int IDX_W  = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset on purpose; resetting it would
    // prevent RAM inference and the contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: non-blocking assignment for all clocked state so every
            // register samples values from before the edge.
            mem[addr] <= di;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/array_ram.sv
// ----------------------------------------------------------------------------
// array_ram
// Single-port synchronous word memory behind the Array channel. Each request
// (valid=1 seen in IDLE) is executed on that edge and acknowledged by a
// one-cycle ready pulse in the following cycle. Throughput is one request
// every two cycles; valid is ignored while acknowledging.
//
// The read-data port is named dout because 'do' is a reserved word.
//
// Optional feature (macro ARRAY_BOUNDS_CHECK_EN):
//   defined   - extra output err; requests with addr >= DEPTH are
//               acknowledged but writes are dropped and reads return 0,
//               with err=1 during that ACK cycle.
//   undefined - no err port; addr >= DEPTH aliases mem[addr % DEPTH].
//
// Ports:
//   clk    in   1       clock, all state updates on posedge
//   nrst   in   1       asynchronous active-low reset
//   addr   in   ADDR_N  word address of the request
//   we     in   1       1 = write di to addr, 0 = read addr
//   di     in   INT_N   write data
//   dout   out  INT_N   read data, changes only on an accepted read
//   valid  in   1       request present; hold inputs stable until ready
//   ready  out  1       one-cycle acknowledge
//   err    out  1       (ARRAY_BOUNDS_CHECK_EN only) out-of-range request
// ----------------------------------------------------------------------------
module array_ram
    import array_ram_pkg::*;
#(
    parameter int ADDR_N = ARRAY_ADDR_N,
    parameter int INT_N  = ARRAY_INT_N,
    parameter int DEPTH  = 1 << ADDR_N
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_N-1:0] addr,
    input  logic              we,
    input  logic [INT_N-1:0]  di,
    output logic [INT_N-1:0]  dout,
    input  logic              valid,
    output logic              ready
`ifdef ARRAY_BOUNDS_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int IDX_W = array_idx_w(DEPTH);

    array_state_e       state, state_n;
    logic               accept;
    logic               in_range;
    logic [IDX_W-1:0]   mem_idx;
    logic [INT_N-1:0]   rd_word;
    logic               err_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
`ifdef ARRAY_BOUNDS_CHECK_EN
    assign in_range = (32'(addr) < DEPTH);
    // Only used when in range, so plain truncation is enough.
    assign mem_idx  = IDX_W'(addr);
`else
    // Every address is serviced; out-of-depth addresses alias by modulo,
    // which folds to plain truncation for power-of-two depths.
    assign in_range = 1'b1;
    assign mem_idx  = IDX_W'(32'(addr) % DEPTH);
`endif

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ARRAY_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        accept  = 1'b0;
        case (state)
            ARRAY_IDLE: begin
                if (valid) begin
                    accept  = 1'b1;
                    state_n = ARRAY_ACK;
                end
            end
            ARRAY_ACK: begin
                ready   = 1'b1;
                state_n = ARRAY_IDLE;
            end
            default: state_n = ARRAY_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    array_ram_core #(
        .IDX_W  (IDX_W),
        .DATA_W (INT_N),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk  (clk),
        .we   (accept && we && in_range),
        .addr (mem_idx),
        .di   (di),
        .dout (rd_word)
    );

    // Read data and error flag are captured on the accepting edge so they
    // are valid for the whole ACK cycle; writes leave dout untouched.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dout  <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= !in_range;
            if (!we) begin
                dout <= in_range ? rd_word : '0;
            end
        end
    end

`ifdef ARRAY_BOUNDS_CHECK_EN
    assign err = ready && err_q;
`else
    // Error flag only has a consumer when bounds checking is built in.
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_array_ram.sv
// ----------------------------------------------------------------------------
// tb_array_ram
// Directed bench for array_ram with DEPTH=16 (ADDR_N=8). Inputs are driven
// and outputs sampled on the falling edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_array_ram;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] addr;
    logic       we;
    logic [7:0] di;
    logic [7:0] dout;
    logic       valid;
    logic       ready;
`ifdef ARRAY_BOUNDS_CHECK_EN
    logic       err;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_do;    // expected held read data

    always #5 clk = ~clk;

    array_ram #(
        .ADDR_N (8),
        .INT_N  (8),
        .DEPTH  (16)
    ) dut (
        .clk   (clk),
        .nrst  (nrst),
        .addr  (addr),
        .we    (we),
        .di    (di),
        .dout  (dout),
        .valid (valid),
        .ready (ready)
`ifdef ARRAY_BOUNDS_CHECK_EN
        ,
        .err   (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_err(input string tag, input logic exp_err);
`ifdef ARRAY_BOUNDS_CHECK_EN
        check(tag, {31'd0, err}, {31'd0, exp_err});
`endif
    endtask

    // One request: present it in an IDLE cycle, expect ready one cycle later.
    // rd_exp is the read data expected for reads; hold keeps valid asserted.
    task automatic req(input string tag, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] rd_exp,
                       input logic exp_err, input logic hold);
        @(negedge clk);
        we = w; addr = a; di = d; valid = 1'b1;
        check({tag, ":idle_ready"}, {31'd0, ready}, 32'd0);
        @(negedge clk);
        check({tag, ":ack_ready"}, {31'd0, ready}, 32'd1);
        if (!w) exp_do = rd_exp;
        check({tag, ":dout"}, {24'd0, dout}, {24'd0, exp_do});
        check_err({tag, ":err"}, exp_err);
        if (!hold) valid = 1'b0;
    endtask

    initial begin
        int pulses;
        // ---- 1: reset with a pending request --------------------------
        nrst = 1'b0; valid = 1'b1; we = 1'b1; addr = 8'd0; di = 8'hA5;
        exp_do = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d:ready", i), {31'd0, ready}, 32'd0);
            check($sformatf("rst%0d:dout", i), {24'd0, dout}, 32'd0);
        end
        nrst = 1'b1;
        @(negedge clk);
        check("rel:ready", {31'd0, ready}, 32'd1);
        check("rel:dout", {24'd0, dout}, 32'd0);
        check_err("rel:err", 1'b0);
        valid = 1'b0;
        @(negedge clk);
        check("rel:ready_drop", {31'd0, ready}, 32'd0);

        // ---- 2: write then read ----------------------------------------
        req("w5", 1'b1, 8'd5, 8'h2A, 8'h00, 1'b0, 1'b0);
        req("r5", 1'b0, 8'd5, 8'h00, 8'h2A, 1'b0, 1'b0);

        // ---- 3: valid held high, 16 writes then 16 reads ---------------
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] a;
            a = 8'(i % 16);
            req($sformatf("burst%0d", i), (i < 16), a, a, a, 1'b0, 1'b1);
            if (ready) pulses++;
        end
        valid = 1'b0;
        check("burst:pulses", pulses, 32'd32);

        // ---- 4: overwrite, read, write leaves dout alone ----------------
        req("w3a", 1'b1, 8'd3, 8'h11, 8'h00, 1'b0, 1'b0);
        req("w3b", 1'b1, 8'd3, 8'h22, 8'h00, 1'b0, 1'b0);
        req("r3",  1'b0, 8'd3, 8'h00, 8'h22, 1'b0, 1'b0);
        req("w7",  1'b1, 8'd7, 8'h33, 8'h00, 1'b0, 1'b0);

        // ---- 5: reset during ACK of a write -----------------------------
        @(negedge clk);
        we = 1'b1; addr = 8'd9; di = 8'h66; valid = 1'b1;
        @(negedge clk);
        check("rstack:ready", {31'd0, ready}, 32'd1);
        nrst = 1'b0; valid = 1'b0;
        exp_do = 8'h00;
        #1;
        check("rstack:ready_drop", {31'd0, ready}, 32'd0);
        check("rstack:dout", {24'd0, dout}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        req("r9", 1'b0, 8'd9, 8'h00, 8'h66, 1'b0, 1'b0);

        // ---- 6: address beyond DEPTH ------------------------------------
        req("w4",  1'b1, 8'd4,  8'h7F, 8'h00, 1'b0, 1'b0);
`ifdef ARRAY_BOUNDS_CHECK_EN
        req("w20", 1'b1, 8'd20, 8'h55, 8'h00, 1'b1, 1'b0);
        req("r20", 1'b0, 8'd20, 8'h00, 8'h00, 1'b1, 1'b0);
        req("r4",  1'b0, 8'd4,  8'h00, 8'h7F, 1'b0, 1'b0);
`else
        // 20 % 16 = 4, so the write lands on word 4.
        req("w20", 1'b1, 8'd20, 8'h55, 8'h00, 1'b0, 1'b0);
        req("r20", 1'b0, 8'd20, 8'h00, 8'h55, 1'b0, 1'b0);
        req("r4",  1'b0, 8'd4,  8'h00, 8'h55, 1'b0, 1'b0);
`endif
        @(negedge clk);
        check("end:ready", {31'd0, ready}, 32'd0);
        check_err("end:err", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
